mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage load/store unit sitting between the EX/MEM pipeline register and the MEM/WB register. It consumes the registered MEM-stage control and data, runs a valid/ready transaction on the data-memory bus, and freezes the upstream pipeline while that transaction is in flight. It performs byte-lane steering for stores and sign/zero extension for loads. It presents registered MEM/WB outputs to writeback.

## Interface
Parameters:
- DATA_WIDTH, from defines (32): data and address width.
- TIMEOUT_CYCLES, 16: maximum cycles in REQ before the access is aborted; 1..255.

Ports:
- clk, input, 1: sole clock; all state updates on posedge.
- rst_n, input, 1: synchronous, active-low reset.
- MEM_MemRead_i, input, 1: load in MEM stage.
- MEM_MemWrite_i, input, 1: store in MEM stage.
- MEM_RegWrite_i, input, 1: instruction writes rd.
- MEM_WBSel_i, input, wb_sel_e: writeback source select.
- MEM_alu_result_i, input, DATA_WIDTH: effective address, or ALU result.
- MEM_instruction_i, input, DATA_WIDTH: funct3 = [14:12], rd = [11:7].
- MEM_wr_data_i, input, DATA_WIDTH: store data, LSB-aligned.
- MEM_pc_plus4_i, input, DATA_WIDTH: link value.
- dmem_valid_o, output, 1: bus request, registered.
- dmem_we_o, output, 1: 1 = store.
- dmem_addr_o, output, DATA_WIDTH: word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata_o, output, DATA_WIDTH: lane-replicated store data.
- dmem_be_o, output, 4: byte enables.
- dmem_ready_i, input, 1: transaction completes in the cycle it is high with valid.
- dmem_rdata_i, input, DATA_WIDTH: read word, valid when ready is high.
- mem_stall_o, output, 1: hold EX_to_MEM and all upstream stages.
- WB_RegWrite_o, output, 1: registered writeback enable.
- WB_WBSel_o, output, wb_sel_e: registered select.
- WB_alu_result_o, output, DATA_WIDTH: registered.
- WB_load_data_o, output, DATA_WIDTH: extended load data.
- WB_pc_plus4_o, output, DATA_WIDTH: registered.
- WB_rd_addr_o, output, 5: registered rd.
- WB_mem_fault_o, output, 1: misaligned, illegal funct3, or timeout.

## Operation
- Access = MEM_MemRead_i | MEM_MemWrite_i. If both are high, the access is treated as a store.
- Fault check, combinational:
  - Halfword (funct3 x01) is misaligned when addr[0]=1.
  - Word (010) is misaligned when addr[1:0]≠0.
  - funct3 011/110/111 is illegal. funct3 1xx on a store is illegal.
- FSM states: IDLE, REQ, DONE.
- IDLE, no access: the MEM/WB register loads the inputs directly. No stall.
- IDLE, access with fault: no bus request. The MEM/WB register loads with RegWrite forced to 0 and fault=1. No stall.
- IDLE, clean access:
  - mem_stall_o=1. The MEM/WB register loads a bubble (RegWrite=0, WBSel=WB_NONE, fault=0).
  - dmem_* are latched: be, wdata, and we are derived from funct3/addr[1:0].
  - State goes to REQ and the counter clears.
- REQ:
  - dmem_valid_o=1; mem_stall_o=1; the MEM/WB register holds the bubble.
  - On dmem_ready_i: rdata is captured, state goes to DONE, and valid drops on the next edge.
  - If the counter reaches TIMEOUT_CYCLES-1 without ready: valid drops, fault is latched, state goes to DONE.
- DONE: mem_stall_o=0. The MEM/WB register loads the instruction's outputs:
  - WB_load_data_o = extended captured data.
  - WB_RegWrite_o = MEM_RegWrite_i & ~fault.
  - WB_mem_fault_o = latched fault.
  - State then goes to IDLE.
- Store steering:
  - SB: be = 1<<addr[1:0]; wdata = {4{wr_data[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{wr_data[15:0]}}.
  - SW: be = 1111.
- Load extraction: select the byte or half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Stores write WB_load_data_o=0.
- dmem_addr_o, dmem_wdata_o, dmem_be_o, and dmem_we_o stay stable for the whole of REQ.

## Timing
- Reset: state IDLE, dmem_valid_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0, mem_stall_o=0, all WB_* = 0, WB_WBSel_o=WB_NONE.
- Non-memory or faulting instruction: 1 cycle from MEM to WB outputs.
- Clean access with ready after k REQ cycles (k≥1): stall is high for 1+k cycles. The WB outputs are valid at the edge ending DONE, so total MEM occupancy is k+2 cycles.
- Ready asserted while not in REQ is ignored.
- Timeout: REQ lasts exactly TIMEOUT_CYCLES cycles, then DONE with fault=1 and RegWrite=0.
- Inputs are stable during stall, because the upstream register holds. The DONE-cycle outputs use the current inputs.
- Reset in REQ or DONE: the next edge forces the reset values. The outstanding bus request is abandoned without waiting for ready.

## Test plan
- ADD passthrough (alu=0x1234, RegWrite=1): WB_alu_result_o=0x1234 next cycle; stall never asserted.
- LB at 0x103 with ready on the 1st REQ cycle and rdata=0x80FF_FF7F: be irrelevant, addr=0x100; WB_load_data_o=0xFFFF_FF80; stall high for 2 cycles.
- SH at 0x202, wr_data=0xABCD, ready after 3 cycles: be=1100, wdata=0xABCD_ABCD, we=1; valid high for exactly 3 cycles; stall high for 4 cycles.
- LW at 0x101: no dmem_valid_o; WB_mem_fault_o=1, WB_RegWrite_o=0 next cycle; no stall.
- LHU at 0x40 with ready never asserted and TIMEOUT_CYCLES=16: valid drops after 16 REQ cycles; fault=1; pipeline released in DONE.
- rst_n low during the 2nd REQ cycle: next cycle valid=0, stall=0, state IDLE, all WB_* reset.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs one valid/ready data-memory transaction per access,
// stalls upstream while it is in flight, and registers the MEM/WB outputs.
package mem_access_pkg;
  typedef enum logic [1:0] {WB_NONE = 2'd0, WB_ALU = 2'd1, WB_MEM = 2'd2, WB_PC = 2'd3} wb_sel_e;
endpackage

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MEM_MemRead_i,
  input  logic                  MEM_MemWrite_i,
  input  logic                  MEM_RegWrite_i,
  input  wb_sel_e               MEM_WBSel_i,
  input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0] MEM_instruction_i,
  input  logic [DATA_WIDTH-1:0] MEM_wr_data_i,
  input  logic [DATA_WIDTH-1:0] MEM_pc_plus4_i,
  output logic                  dmem_valid_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [3:0]            dmem_be_o,
  input  logic                  dmem_ready_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  mem_stall_o,
  output logic                  WB_RegWrite_o,
  output wb_sel_e               WB_WBSel_o,
  output logic [DATA_WIDTH-1:0] WB_alu_result_o,
  output logic [DATA_WIDTH-1:0] WB_load_data_o,
  output logic [DATA_WIDTH-1:0] WB_pc_plus4_o,
  output logic [4:0]            WB_rd_addr_o,
  output logic                  WB_mem_fault_o
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q;
  logic [7:0]            cnt_q;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [2:0]            funct3;
  logic [1:0]            addr_lo;
  logic                  access, is_store, misaligned, illegal, fault_now, clean_access;
  logic [3:0]            be_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] load_ext;
  logic                  unused_instr;

  assign funct3       = MEM_instruction_i[14:12];
  assign addr_lo      = MEM_alu_result_i[1:0];
  assign access       = MEM_MemRead_i | MEM_MemWrite_i;
  assign is_store     = MEM_MemWrite_i;
  assign unused_instr = ^{MEM_instruction_i[DATA_WIDTH-1:15], MEM_instruction_i[6:0]};

  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
    illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
              (is_store && funct3[2]);
  end

  assign fault_now    = access & (misaligned | illegal);
  assign clean_access = access & ~fault_now;

  // Stall covers the launching IDLE cycle plus every REQ cycle; nothing stalls during reset.
  assign mem_stall_o = rst_n & ((state_q == StIdle && clean_access) || state_q == StReq);

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = MEM_wr_data_i;
    case (funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr_lo;
        wdata_next = {4{MEM_wr_data_i[7:0]}};
      end
      2'b01: begin
        be_next    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{MEM_wr_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte  = rdata_q[{addr_lo, 3'b000} +: 8];
    ld_half  = addr_lo[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_ext = rdata_q;
    case (funct3)
      3'b000:  load_ext = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: load_ext = rdata_q;
    endcase
    if (is_store) load_ext = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      fault_q         <= 1'b0;
      rdata_q         <= '0;
      dmem_valid_o    <= 1'b0;
      dmem_we_o       <= 1'b0;
      dmem_addr_o     <= '0;
      dmem_wdata_o    <= '0;
      dmem_be_o       <= '0;
      WB_RegWrite_o   <= 1'b0;
      WB_WBSel_o      <= WB_NONE;
      WB_alu_result_o <= '0;
      WB_load_data_o  <= '0;
      WB_pc_plus4_o   <= '0;
      WB_rd_addr_o    <= '0;
      WB_mem_fault_o  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (clean_access) begin
            state_q         <= StReq;
            cnt_q           <= '0;
            fault_q         <= 1'b0;
            rdata_q         <= '0;
            dmem_valid_o    <= 1'b1;
            dmem_we_o       <= is_store;
            dmem_addr_o     <= {MEM_alu_result_i[DATA_WIDTH-1:2], 2'b00};
            dmem_wdata_o    <= wdata_next;
            dmem_be_o       <= be_next;
            WB_RegWrite_o   <= 1'b0;
            WB_WBSel_o      <= WB_NONE;
            WB_alu_result_o <= '0;
            WB_load_data_o  <= '0;
            WB_pc_plus4_o   <= '0;
            WB_rd_addr_o    <= '0;
            WB_mem_fault_o  <= 1'b0;
          end else begin
            WB_RegWrite_o   <= MEM_RegWrite_i & ~fault_now;
            WB_WBSel_o      <= MEM_WBSel_i;
            WB_alu_result_o <= MEM_alu_result_i;
            WB_load_data_o  <= '0;
            WB_pc_plus4_o   <= MEM_pc_plus4_i;
            WB_rd_addr_o    <= MEM_instruction_i[11:7];
            WB_mem_fault_o  <= fault_now;
          end
        end
        StReq: begin
          if (dmem_ready_i) begin
            rdata_q      <= dmem_rdata_i;
            dmem_valid_o <= 1'b0;
            state_q      <= StDone;
          end else if (cnt_q == CntLast) begin
            dmem_valid_o <= 1'b0;
            fault_q      <= 1'b1;
            state_q      <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          WB_RegWrite_o   <= MEM_RegWrite_i & ~fault_q;
          WB_WBSel_o      <= MEM_WBSel_i;
          WB_alu_result_o <= MEM_alu_result_i;
          WB_load_data_o  <= load_ext;
          WB_pc_plus4_o   <= MEM_pc_plus4_i;
          WB_rd_addr_o    <= MEM_instruction_i[11:7];
          WB_mem_fault_o  <= fault_q;
          state_q         <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a per-instruction reference model.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int unsigned Timeout = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MEM_MemRead_i = 1'b0, MEM_MemWrite_i = 1'b0, MEM_RegWrite_i = 1'b0;
  wb_sel_e     MEM_WBSel_i = WB_NONE;
  logic [31:0] MEM_alu_result_i = '0, MEM_instruction_i = '0;
  logic [31:0] MEM_wr_data_i = '0, MEM_pc_plus4_i = '0;
  logic        dmem_valid_o, dmem_we_o, dmem_ready_i = 1'b0;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i = '0;
  logic [3:0]  dmem_be_o;
  logic        mem_stall_o, WB_RegWrite_o, WB_mem_fault_o;
  wb_sel_e     WB_WBSel_o;
  logic [31:0] WB_alu_result_o, WB_load_data_o, WB_pc_plus4_o;
  logic [4:0]  WB_rd_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(Timeout)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_MemRead_i(MEM_MemRead_i), .MEM_MemWrite_i(MEM_MemWrite_i),
    .MEM_RegWrite_i(MEM_RegWrite_i), .MEM_WBSel_i(MEM_WBSel_i),
    .MEM_alu_result_i(MEM_alu_result_i), .MEM_instruction_i(MEM_instruction_i),
    .MEM_wr_data_i(MEM_wr_data_i), .MEM_pc_plus4_i(MEM_pc_plus4_i),
    .dmem_valid_o(dmem_valid_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_ready_i(dmem_ready_i),
    .dmem_rdata_i(dmem_rdata_i), .mem_stall_o(mem_stall_o),
    .WB_RegWrite_o(WB_RegWrite_o), .WB_WBSel_o(WB_WBSel_o),
    .WB_alu_result_o(WB_alu_result_o), .WB_load_data_o(WB_load_data_o),
    .WB_pc_plus4_o(WB_pc_plus4_o), .WB_rd_addr_o(WB_rd_addr_o),
    .WB_mem_fault_o(WB_mem_fault_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, " ctl"}, {dmem_valid_o, dmem_we_o, dmem_be_o, mem_stall_o}, 0);
    check_eq({tag, " addr"}, dmem_addr_o, 0);
    check_eq({tag, " wdata"}, dmem_wdata_o, 0);
    check_eq({tag, " wb_ctl"}, {WB_RegWrite_o, WB_WBSel_o, WB_mem_fault_o, WB_rd_addr_o},
             {1'b0, WB_NONE, 1'b0, 5'd0});
    check_eq({tag, " wb_alu"}, WB_alu_result_o, 0);
    check_eq({tag, " wb_load"}, WB_load_data_o, 0);
    check_eq({tag, " wb_pc"}, WB_pc_plus4_o, 0);
  endtask

  task automatic drive(input logic mr, input logic mw, input logic rw, input wb_sel_e sel,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] pc);
    logic [31:0] instr;
    instr              = $urandom;
    instr[14:12]       = f3;
    instr[11:7]        = rd;
    MEM_MemRead_i      = mr;
    MEM_MemWrite_i     = mw;
    MEM_RegWrite_i     = rw;
    MEM_WBSel_i        = sel;
    MEM_instruction_i  = instr;
    MEM_alu_result_i   = addr;
    MEM_wr_data_i      = wd;
    MEM_pc_plus4_i     = pc;
  endtask

  // lat = number of REQ cycles before ready; 0 means the bus never answers.
  task automatic run_instr(input string tag, input logic mr, input logic mw, input logic rw,
                           input wb_sel_e sel, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] pc, input logic [31:0] rdata, input int lat);
    int          stall_cnt = 0, valid_cnt = 0, cyc = 0;
    bit          done = 0;
    bit          access, store, mis, ill, clean, tmo, exp_fault;
    int          exp_req;
    logic [31:0] exp_be, exp_wd, exp_ld, b, h;

    access    = mr | mw;
    store     = mw;
    mis       = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 0);
    ill       = (f3 == 3) || (f3 == 6) || (f3 == 7) || (store && f3 >= 4);
    clean     = access && !mis && !ill;
    tmo       = clean && lat == 0;
    exp_req   = !clean ? 0 : (tmo ? Timeout : lat);
    exp_fault = access && (mis || ill || tmo);

    case (f3[1:0])
      2'd0:    begin exp_be = 32'd1 << addr[1:0]; exp_wd = {4{wd[7:0]}}; end
      2'd1:    begin exp_be = addr[1] ? 32'hC : 32'h3; exp_wd = {2{wd[15:0]}}; end
      default: begin exp_be = 32'hF; exp_wd = wd; end
    endcase

    b = (rdata >> (addr[1:0] * 8)) & 32'hFF;
    h = (rdata >> (addr[1] ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'd0:    exp_ld = (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    exp_ld = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    exp_ld = b;
      3'd5:    exp_ld = h;
      default: exp_ld = rdata;
    endcase
    if (!(clean && !store && !tmo)) exp_ld = 0;

    @(negedge clk);
    drive(mr, mw, rw, sel, f3, rd, addr, wd, pc);
    while (!done) begin
      #1;
      if (dmem_valid_o) begin
        valid_cnt++;
        check_eq({tag, " addr"}, dmem_addr_o, {addr[31:2], 2'b00});
        check_eq({tag, " we"}, 32'(dmem_we_o), 32'(store));
        check_eq({tag, " bubble"}, {WB_RegWrite_o, WB_WBSel_o, WB_mem_fault_o},
                 {1'b0, WB_NONE, 1'b0});
        if (store) begin
          check_eq({tag, " be"}, 32'(dmem_be_o), exp_be);
          check_eq({tag, " wdata"}, dmem_wdata_o, exp_wd);
        end
        dmem_ready_i = (lat != 0 && valid_cnt == lat);
        dmem_rdata_i = dmem_ready_i ? rdata : $urandom;
      end else begin
        dmem_ready_i = 1'($urandom_range(0, 1));
        dmem_rdata_i = $urandom;
      end
      if (mem_stall_o) stall_cnt++;
      else done = 1;
      cyc++;
      if (cyc > 300) begin
        check_eq({tag, " bounded"}, 32'(mem_stall_o), 0);
        done = 1;
      end
      @(posedge clk);
      if (!done) @(negedge clk);
    end
    #1;
    dmem_ready_i = 1'b0;
    check_eq({tag, " stall_cycles"}, stall_cnt, clean ? 1 + exp_req : 0);
    check_eq({tag, " valid_cycles"}, valid_cnt, exp_req);
    check_eq({tag, " wb_regwrite"}, 32'(WB_RegWrite_o), 32'(rw && !exp_fault));
    check_eq({tag, " wb_fault"}, 32'(WB_mem_fault_o), 32'(exp_fault));
    check_eq({tag, " wb_sel"}, 32'(WB_WBSel_o), 32'(sel));
    check_eq({tag, " wb_alu"}, WB_alu_result_o, addr);
    check_eq({tag, " wb_pc"}, WB_pc_plus4_o, pc);
    check_eq({tag, " wb_rd"}, 32'(WB_rd_addr_o), 32'(rd));
    check_eq({tag, " wb_load"}, WB_load_data_o, exp_ld);
  endtask

  initial begin
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("add", 0, 0, 1, WB_ALU, 3'd0, 5'd5, 32'h1234, 32'h0, 32'h44, 32'h0, 1);
    run_instr("lb", 1, 0, 1, WB_MEM, 3'd0, 5'd6, 32'h103, 32'h0, 32'h48, 32'h80FF_FF7F, 1);
    run_instr("sh", 0, 1, 0, WB_NONE, 3'd1, 5'd0, 32'h202, 32'hABCD, 32'h4C, 32'h0, 3);
    run_instr("lw_mis", 1, 0, 1, WB_MEM, 3'd2, 5'd7, 32'h101, 32'h0, 32'h50, 32'h0, 1);
    run_instr("lhu_tmo", 1, 0, 1, WB_MEM, 3'd5, 5'd8, 32'h40, 32'h0, 32'h54, 32'h0, 0);
    run_instr("sw", 1, 1, 0, WB_NONE, 3'd2, 5'd0, 32'h3C, 32'hDEAD_BEEF, 32'h58, 32'h0, 2);

    // Reset asserted in the second REQ cycle of a load.
    @(negedge clk);
    drive(1, 0, 1, WB_MEM, 3'd2, 5'd9, 32'h300, 32'h0, 32'h60);
    cyc = 0;
    while (!(dmem_valid_o && cyc >= 2) && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq("rst_req reached", 32'(dmem_valid_o), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_state("rst_req");
    @(negedge clk);
    drive(0, 0, 0, WB_NONE, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      int          kind, lat;
      logic        mr, mw;
      kind = $urandom_range(0, 3);
      mr   = (kind == 1) || (kind == 3);
      mw   = (kind == 2) || (kind == 3);
      lat  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      run_instr($sformatf("rnd%0d", i), mr, mw, 1'($urandom_range(0, 1)),
                wb_sel_e'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
